ccip_mmio_csr_responder: RTL and testbench
==========================================

# ccip_mmio_csr_responder

AFU-side CCI-P MMIO responder: accepts host MMIO reads and writes from the CCI-P c0 receive path, maintains the AFU device-feature header and a small CSR file, and returns read data on the c2 transmit path. It sits in the AFU clock domain downstream of the async shim, beside the traffic engine that issues host memory requests. The host initiates; this block answers with fixed latency and no backpressure.

## Interface
- DFH_VALUE, 64'h1000_0000_0000_0001, constant returned at the device-feature header register
- AFU_ID_L, 64'h0, low half of the AFU GUID
- AFU_ID_H, 64'h0, high half of the AFU GUID
- NUM_SCRATCH, 4, number of 64-bit scratch registers (1..8)

- afu_clk  in  1  AFU clock; everything is single-clock.
- afu_softreset_n  in  1  asynchronous, active-low reset.
- mmio_rd_valid  in  1  MMIO read request this cycle.
- mmio_wr_valid  in  1  MMIO write request this cycle.
- mmio_addr  in  16  DW (4-byte) address from the CCI-P MMIO header.
- mmio_len  in  2  0 = 4B, 1 = 8B, 2 = 64B (unsupported), 3 = reserved.
- mmio_tid  in  9  read transaction ID.
- mmio_wdata  in  64  write data.
- rsp_valid  out  1  c2 MMIO read response valid.
- rsp_tid  out  9  echoed tid.
- rsp_data  out  64  response data.
- csr_ctl  out  64  current CTL register (bit 0 always 0).
- ctl_start_pulse  out  1  one-cycle start strobe.

## Operation
- Byte address = mmio_addr*4; qword index = mmio_addr[15:1]. Register map (byte):
  - 0x000 DFH (RO, DFH_VALUE).
  - 0x008 AFU_ID_L (RO); 0x010 AFU_ID_H (RO).
  - 0x018, 0x020 reserved DFH words (RO 0).
  - 0x028 CTL (RW): bits 63:1 stored; bit 0 write-1 produces ctl_start_pulse and reads 0.
  - 0x030 CYCLES (RO): free-running 64-bit counter, +1 every cycle, wraps 2^64-1 -> 0. Any write clears it.
  - 0x038 + 8*i SCRATCH[i] (RW), i < NUM_SCRATCH.
  - All other addresses: read 0, writes ignored.
- 8B access: mmio_addr[0] must be 0; if 1, write ignored, read returns 0.
- 4B write: updates only the addressed DW half (addr[0]=0 -> [31:0], 1 -> [63:32]) from mmio_wdata[31:0]. For CTL bit 0 the strobe fires only when the low half is written with bit 0 = 1. 4B write to CYCLES clears the whole counter.
- 4B read: rsp_data = {32'h0, addressed DW}.
- mmio_len 2 or 3: writes ignored; reads respond with rsp_data = 0, so the host never times out.
- Every read produces exactly one response; reads are never dropped except by reset.

## Timing
- Two-stage pipeline. Stage 1 (cycle N+1): registered tid, addr, len. Stage 2 (cycle N+2): registered data mux output. Read accepted in cycle N -> rsp_valid high in cycle N+2 for exactly one cycle. Throughput: one read per cycle, back-to-back, in order.
- Writes take effect at the clock edge ending cycle N; a read in cycle N+1 sees the new value.
- Simultaneous mmio_rd_valid and mmio_wr_valid in cycle N: both are processed; the read returns the pre-write value.
- CYCLES read in cycle N returns the counter value held during cycle N+1. A write in cycle N makes the counter 0 in cycle N+1 and 1 in cycle N+2.
- ctl_start_pulse is high in cycle N+1 only for a qualifying write in cycle N. Consecutive qualifying writes give consecutive pulses.
- Reset (asynchronous, immediate): rsp_valid=0, rsp_tid=0, rsp_data=0, csr_ctl=0, ctl_start_pulse=0. SCRATCH, CTL and CYCLES are set to 0 and pipeline valids are cleared. In-flight reads are discarded. CYCLES starts counting on the first edge after deassertion.

## Test plan
- Read DFH: rd at addr 0x0000, len 1, tid 0x1A5 -> two cycles later rsp_valid=1, rsp_tid=0x1A5, rsp_data=DFH_VALUE; AFU_ID_L/H at DW 0x0002/0x0004 likewise.
- Scratch RW: 8B write 0xDEAD_BEEF_0123_4567 to SCRATCH[2] (DW 0x0012), then read next cycle -> same value. 4B write 0xCAFEF00D to DW 0x0013, then 4B reads of DW 0x0012 and 0x0013 -> 0x01234567 and 0xCAFEF00D.
- Back-to-back reads with tids 1..8 on consecutive cycles -> eight consecutive responses, in order, each 2 cycles after its request.
- CTL: write 0x5 -> ctl_start_pulse high one cycle, csr_ctl=0x4, and a read of CTL returns 0x4.
- CYCLES: write any value in cycle N, read in cycle N+3 -> rsp_data=3. Force the counter to 2^64-1 -> the next cycle reads 0.
- Error/reset cases: 64B read and a misaligned 8B read (DW 0x0001) -> response with data 0. Assert reset with two reads in flight -> no responses, all outputs 0; after release, scratch reads 0.

Source files
------------

// File: rtl/ccip_mmio_csr_responder_if.sv
// MMIO request/response bundle between the CCI-P shim (host side) and the
// AFU CSR responder. Signal names follow the CCI-P header fields.
interface ccip_mmio_csr_responder_if;
    logic        mmio_rd_valid;
    logic        mmio_wr_valid;
    logic [15:0] mmio_addr;
    logic [1:0]  mmio_len;
    logic [8:0]  mmio_tid;
    logic [63:0] mmio_wdata;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;

    modport master (
        output mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_len, mmio_tid, mmio_wdata,
        input  rsp_valid, rsp_tid, rsp_data
    );

    modport slave (
        input  mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_len, mmio_tid, mmio_wdata,
        output rsp_valid, rsp_tid, rsp_data
    );
endinterface

// File: rtl/ccip_mmio_csr_responder.sv
// AFU-side CCI-P MMIO responder: device-feature header, AFU GUID, CTL,
// free-running CYCLES counter and a small scratch file. Reads answer with a
// fixed two-cycle latency, one per cycle, with no backpressure.
module ccip_mmio_csr_responder #(
    parameter logic [63:0] DFH_VALUE   = 64'h1000_0000_0000_0001,
    parameter logic [63:0] AFU_ID_L    = 64'h0,
    parameter logic [63:0] AFU_ID_H    = 64'h0,
    parameter int          NUM_SCRATCH = 4
) (
    input  logic                            afu_clk,
    input  logic                            afu_softreset_n,
    ccip_mmio_csr_responder_if.slave        mmio,
    output logic [63:0]                     csr_ctl,
    output logic                            ctl_start_pulse
);
    // Qword indices (byte address / 8)
    localparam logic [14:0] QW_DFH      = 15'd0;
    localparam logic [14:0] QW_ID_L     = 15'd1;
    localparam logic [14:0] QW_ID_H     = 15'd2;
    localparam logic [14:0] QW_CTL      = 15'd5;
    localparam logic [14:0] QW_CYCLES   = 15'd6;
    localparam logic [14:0] QW_SCRATCH0 = 15'd7;

    localparam logic [1:0] LEN_4B = 2'd0;
    localparam logic [1:0] LEN_8B = 2'd1;

    // Merge write data into an existing qword: full 8B replace, or a 4B
    // update of the addressed DW half from the low 32 bits of the write data.
    function automatic logic [63:0] mergeWrite(
        input logic [63:0] oldVal,
        input logic [63:0] wdata,
        input logic        full,
        input logic        hiHalf
    );
        logic [63:0] res;
        if (full)
            res = wdata;
        else if (hiHalf)
            res = {wdata[31:0], oldVal[31:0]};
        else
            res = {oldVal[63:32], wdata[31:0]};
        return res;
    endfunction

    logic [14:0] qword;
    logic        addrHi;
    logic        wrFull;
    logic        wrHalf;
    logic        wrAccept;
    logic        hitCtl;
    logic        hitCycles;
    logic [63:0] ctlMerged;

    logic [63:1] ctlBits;
    logic [63:0] cycleCount;
    logic [63:0] scratch [NUM_SCRATCH];

    logic [63:0] rdSnap;
    logic        s1Valid;
    logic [8:0]  s1Tid;
    logic [1:0]  s1Len;
    logic        s1Hi;
    logic        s1Cycles;
    logic [63:0] s1Snap;
    logic [63:0] s1Qword;
    logic [63:0] rspNext;

    assign qword   = mmio.mmio_addr[15:1];
    assign addrHi  = mmio.mmio_addr[0];
    assign csr_ctl = {ctlBits, 1'b0};

    // Write qualification: 8B must be qword aligned; 64B and reserved lengths are dropped.
    always_comb begin
        wrFull    = mmio.mmio_wr_valid && (mmio.mmio_len == LEN_8B) && !addrHi;
        wrHalf    = mmio.mmio_wr_valid && (mmio.mmio_len == LEN_4B);
        wrAccept  = wrFull || wrHalf;
        hitCtl    = wrAccept && (qword == QW_CTL);
        hitCycles = wrAccept && (qword == QW_CYCLES);
        ctlMerged = mergeWrite({ctlBits, 1'b0}, mmio.mmio_wdata, wrFull, addrHi);
    end

    // CTL storage and start strobe; bit 0 is never stored, it only fires the strobe.
    always_ff @(posedge afu_clk or negedge afu_softreset_n) begin
        if (!afu_softreset_n) begin
            ctlBits         <= '0;
            ctl_start_pulse <= 1'b0;
        end else begin
            if (hitCtl)
                ctlBits <= ctlMerged[63:1];
            ctl_start_pulse <= hitCtl && ctlMerged[0];
        end
    end

    // Free-running cycle counter; any accepted write to it restarts from zero.
    always_ff @(posedge afu_clk or negedge afu_softreset_n) begin
        if (!afu_softreset_n)
            cycleCount <= '0;
        else if (hitCycles)
            cycleCount <= '0;
        else
            cycleCount <= cycleCount + 64'd1;
    end

    // Scratch register file.
    always_ff @(posedge afu_clk or negedge afu_softreset_n) begin
        if (!afu_softreset_n) begin
            for (int i = 0; i < NUM_SCRATCH; i++)
                scratch[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SCRATCH; i++)
                if (wrAccept && (qword == QW_SCRATCH0 + 15'(i)))
                    scratch[i] <= mergeWrite(scratch[i], mmio.mmio_wdata, wrFull, addrHi);
        end
    end

    // Snapshot of the addressed register during the request cycle, so a read
    // issued alongside a write returns the pre-write value. CYCLES is excluded
    // here and picked up live in stage 2.
    always_comb begin
        case (qword)
            QW_DFH:  rdSnap = DFH_VALUE;
            QW_ID_L: rdSnap = AFU_ID_L;
            QW_ID_H: rdSnap = AFU_ID_H;
            QW_CTL:  rdSnap = {ctlBits, 1'b0};
            default: rdSnap = '0;
        endcase
        for (int i = 0; i < NUM_SCRATCH; i++)
            if (qword == QW_SCRATCH0 + 15'(i))
                rdSnap = scratch[i];
    end

    // Stage 1: capture the read request.
    always_ff @(posedge afu_clk or negedge afu_softreset_n) begin
        if (!afu_softreset_n) begin
            s1Valid  <= 1'b0;
            s1Tid    <= '0;
            s1Len    <= '0;
            s1Hi     <= 1'b0;
            s1Cycles <= 1'b0;
            s1Snap   <= '0;
        end else begin
            s1Valid <= mmio.mmio_rd_valid;
            if (mmio.mmio_rd_valid) begin
                s1Tid    <= mmio.mmio_tid;
                s1Len    <= mmio.mmio_len;
                s1Hi     <= addrHi;
                s1Cycles <= (qword == QW_CYCLES);
                s1Snap   <= rdSnap;
            end
        end
    end

    // Response shaping: 8B aligned returns the qword, 4B returns the addressed
    // DW zero-extended, anything else answers with zero so the host never stalls.
    always_comb begin
        s1Qword = s1Cycles ? cycleCount : s1Snap;
        rspNext = '0;
        if ((s1Len == LEN_8B) && !s1Hi)
            rspNext = s1Qword;
        else if (s1Len == LEN_4B)
            rspNext = {32'h0, (s1Hi ? s1Qword[63:32] : s1Qword[31:0])};
    end

    // Stage 2: registered response onto c2.
    always_ff @(posedge afu_clk or negedge afu_softreset_n) begin
        if (!afu_softreset_n) begin
            mmio.rsp_valid <= 1'b0;
            mmio.rsp_tid   <= '0;
            mmio.rsp_data  <= '0;
        end else begin
            mmio.rsp_valid <= s1Valid;
            if (s1Valid) begin
                mmio.rsp_tid  <= s1Tid;
                mmio.rsp_data <= rspNext;
            end
        end
    end
endmodule

// File: tb/tb_ccip_mmio_csr_responder.sv
// Scoreboard bench for the MMIO CSR responder: reads push the expected
// response (tid, data, arrival cycle); a monitor pops on every rsp_valid.
module tb_ccip_mmio_csr_responder;
    localparam logic [63:0] DFH = 64'h1000_0000_0000_0001;
    localparam logic [63:0] IDL = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] IDH = 64'hFEDC_BA98_7654_3210;

    logic        clk;
    logic        rstN;
    logic [63:0] csrCtl;
    logic        startPulse;
    int          cyc;
    int          checks;
    int          failures;

    typedef struct {
        logic [8:0]  tid;
        logic [63:0] data;
        int          cyc;
    } expT;

    expT expQ[$];

    ccip_mmio_csr_responder_if bus();

    ccip_mmio_csr_responder #(
        .DFH_VALUE  (DFH),
        .AFU_ID_L   (IDL),
        .AFU_ID_H   (IDH),
        .NUM_SCRATCH(4)
    ) dut (
        .afu_clk        (clk),
        .afu_softreset_n(rstN),
        .mmio           (bus),
        .csr_ctl        (csrCtl),
        .ctl_start_pulse(startPulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: compares every response against the scoreboard head
    // and flags responses that never arrived by their due cycle.
    always @(negedge clk) begin
        expT e;
        if (bus.rsp_valid) begin
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rsp: got tid=%h data=%h with nothing outstanding",
                         bus.rsp_tid, bus.rsp_data);
            end else begin
                e = expQ.pop_front();
                if (bus.rsp_tid !== e.tid || bus.rsp_data !== e.data || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL rsp: got tid=%h data=%h cyc=%0d expected tid=%h data=%h cyc=%0d",
                             bus.rsp_tid, bus.rsp_data, cyc, e.tid, e.data, e.cyc);
                end
            end
        end else if (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
            checks++;
            failures++;
            e = expQ.pop_front();
            $display("FAIL missing_rsp: got no response by cyc=%0d expected tid=%h data=%h",
                     cyc, e.tid, e.data);
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [1:0] l, input logic [8:0] t, input logic [63:0] wd);
        @(negedge clk);
        bus.mmio_rd_valid = rd;
        bus.mmio_wr_valid = wr;
        bus.mmio_addr     = a;
        bus.mmio_len      = l;
        bus.mmio_tid      = t;
        bus.mmio_wdata    = wd;
    endtask

    task automatic pushExp(input logic [8:0] t, input logic [63:0] d);
        expT e;
        e.tid  = t;
        e.data = d;
        e.cyc  = cyc + 2;
        expQ.push_back(e);
    endtask

    task automatic doRead(input logic [15:0] a, input logic [1:0] l,
                          input logic [8:0] t, input logic [63:0] d);
        drive(1'b1, 1'b0, a, l, t, 64'h0);
        pushExp(t, d);
    endtask

    task automatic doWrite(input logic [15:0] a, input logic [1:0] l, input logic [63:0] wd);
        drive(1'b0, 1'b1, a, l, 9'h0, wd);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 16'h0, 2'd0, 9'h0, 64'h0);
    endtask

    initial begin
        cyc = 0;
        checks = 0;
        failures = 0;
        rstN = 1'b0;
        bus.mmio_rd_valid = 1'b0;
        bus.mmio_wr_valid = 1'b0;
        bus.mmio_addr = '0;
        bus.mmio_len = '0;
        bus.mmio_tid = '0;
        bus.mmio_wdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        check("rst_rsp_tid", 64'(bus.rsp_tid), 64'h0);
        check("rst_rsp_data", bus.rsp_data, 64'h0);
        check("rst_csr_ctl", csrCtl, 64'h0);
        check("rst_pulse", 64'(startPulse), 64'h0);
        rstN = 1'b1;

        // Header registers, 8B and 4B
        doRead(16'h0000, 2'd1, 9'h1A5, DFH);
        doRead(16'h0002, 2'd1, 9'h002, IDL);
        doRead(16'h0004, 2'd1, 9'h003, IDH);
        doRead(16'h0001, 2'd0, 9'h004, 64'h0000_0000_1000_0000);
        doRead(16'h0006, 2'd1, 9'h005, 64'h0);
        doRead(16'h0008, 2'd1, 9'h006, 64'h0);
        idle(2);

        // Scratch 8B and 4B accesses
        doWrite(16'h0012, 2'd1, 64'hDEAD_BEEF_0123_4567);
        doRead(16'h0012, 2'd1, 9'h010, 64'hDEAD_BEEF_0123_4567);
        doWrite(16'h0013, 2'd0, 64'h0000_0000_CAFE_F00D);
        doRead(16'h0012, 2'd0, 9'h011, 64'h0000_0000_0123_4567);
        doRead(16'h0013, 2'd0, 9'h012, 64'h0000_0000_CAFE_F00D);
        doRead(16'h0012, 2'd1, 9'h013, 64'hCAFE_F00D_0123_4567);

        // Simultaneous read and write: read sees the old value
        drive(1'b1, 1'b1, 16'h000E, 2'd1, 9'h020, 64'h1111_2222_3333_4444);
        pushExp(9'h020, 64'h0);
        doRead(16'h000E, 2'd1, 9'h021, 64'h1111_2222_3333_4444);
        idle(2);

        // Back-to-back reads, tids 1..8
        for (int i = 1; i <= 8; i++) begin
            if (i % 2 == 1)
                doRead(16'h0012, 2'd1, 9'(i), 64'hCAFE_F00D_0123_4567);
            else
                doRead(16'h000E, 2'd1, 9'(i), 64'h1111_2222_3333_4444);
        end
        idle(3);

        // CTL write 0x5: strobe one cycle, bit 0 reads back 0
        doWrite(16'h000A, 2'd1, 64'h5);
        idle(1);
        check("ctl_pulse_on", 64'(startPulse), 64'h1);
        check("ctl_value", csrCtl, 64'h4);
        idle(1);
        check("ctl_pulse_off", 64'(startPulse), 64'h0);
        doRead(16'h000A, 2'd1, 9'h030, 64'h4);

        // Consecutive 4B low writes with bit 0 set: consecutive strobes
        doWrite(16'h000A, 2'd0, 64'h1);
        doWrite(16'h000A, 2'd0, 64'h1);
        check("ctl_pulse_b2b_1", 64'(startPulse), 64'h1);
        idle(1);
        check("ctl_pulse_b2b_2", 64'(startPulse), 64'h1);
        idle(1);
        check("ctl_pulse_b2b_off", 64'(startPulse), 64'h0);

        // 4B high-half write: no strobe even with bit 0 set
        doWrite(16'h000B, 2'd0, 64'h1);
        idle(1);
        check("ctl_hi_no_pulse", 64'(startPulse), 64'h0);
        check("ctl_hi_value", csrCtl, 64'h0000_0001_0000_0000);
        doRead(16'h000A, 2'd1, 9'h031, 64'h0000_0001_0000_0000);
        doRead(16'h000B, 2'd0, 9'h032, 64'h1);
        idle(2);

        // CYCLES: clear in N, read in N+3 returns 3
        doWrite(16'h000C, 2'd1, 64'h1234);
        idle(2);
        doRead(16'h000C, 2'd1, 9'h040, 64'd3);
        idle(2);

        // CYCLES wrap: counter at all-ones this cycle, reads 0 next cycle
        drive(1'b1, 1'b0, 16'h000C, 2'd1, 9'h041, 64'h0);
        force dut.cycleCount = 64'hFFFF_FFFF_FFFF_FFFF;
        pushExp(9'h041, 64'h0);
        #1 release dut.cycleCount;
        doRead(16'h000C, 2'd1, 9'h042, 64'h1);
        idle(2);

        // Unsupported lengths, misalignment, unmapped addresses
        doRead(16'h0012, 2'd2, 9'h050, 64'h0);
        doRead(16'h0012, 2'd3, 9'h051, 64'h0);
        doRead(16'h0001, 2'd1, 9'h052, 64'h0);
        doWrite(16'h0013, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        doWrite(16'h0012, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        doRead(16'h0012, 2'd1, 9'h053, 64'hCAFE_F00D_0123_4567);
        doWrite(16'h0016, 2'd1, 64'hABCD);
        doRead(16'h0016, 2'd1, 9'h054, 64'h0);
        doRead(16'h0040, 2'd1, 9'h055, 64'h0);
        idle(3);

        // Reset with two reads in flight: neither may respond
        drive(1'b1, 1'b0, 16'h0012, 2'd1, 9'h060, 64'h0);
        drive(1'b1, 1'b0, 16'h0000, 2'd1, 9'h061, 64'h0);
        @(posedge clk);
        #1;
        rstN = 1'b0;
        bus.mmio_rd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst2_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        check("rst2_rsp_tid", 64'(bus.rsp_tid), 64'h0);
        check("rst2_rsp_data", bus.rsp_data, 64'h0);
        check("rst2_csr_ctl", csrCtl, 64'h0);
        check("rst2_pulse", 64'(startPulse), 64'h0);
        rstN = 1'b1;
        idle(1);
        doRead(16'h0012, 2'd1, 9'h070, 64'h0);
        doRead(16'h000E, 2'd1, 9'h071, 64'h0);
        doRead(16'h000A, 2'd1, 9'h072, 64'h0);
        idle(5);

        check("outstanding_after_drain", 64'(expQ.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
